// File: rtl/dmem_responder.sv
// dmem_responder: CPU data-memory bus responder.
// Serves word loads/stores from a synchronous-read RAM with a fixed number of
// wait states, and maps a 4-bit LED register and a switch/button status word
// into the same word address space. The CPU is frozen through CPU_HALT_N until
// each access reaches its response cycle.
module dmem_responder #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] LED_ADDR    = 32'h100,
    parameter logic [31:0] SW_ADDR     = 32'h101
) (
    input  logic        CK_REF,
    input  logic        RST_N,
    input  logic        MEM_ACCESS_EN,
    input  logic        MEM_ACCESS_READ_WRN,
    input  logic [31:0] MEM_ACCESS_ADDRESS_BUS,
    input  logic [31:0] MEM_ACCESS_DATA_OUT_BUS,
    output logic [31:0] MEM_ACCESS_DATA_IN_BUS,
    input  logic        EXT_HALT_N,
    output logic        CPU_HALT_N,
    input  logic [3:0]  SW,
    input  logic [3:0]  BTN,
    output logic [3:0]  LED,
    output logic        ADDR_ERR
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 32'd1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          rwn_q;
    logic [31:0]   data_in;
    logic [3:0]    led_q;
    logic          addr_err_q;

    logic [3:0]    sw_meta;
    logic [3:0]    sw_sync;
    logic [3:0]    btn_meta;
    logic [3:0]    btn_sync;

    logic [31:0]   ram [DEPTH];

    logic          accept;
    logic          resp_entry;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic          cur_rwn;
    logic          hit_ram;
    logic          hit_led;
    logic          hit_sw;
    logic [AW-1:0] ram_idx;
    logic [31:0]   rd_val;
    logic          ram_we;

    // Request acceptance, response-entry detection and address decode.
    // With zero wait states the access completes straight out of IDLE, so the
    // decode must look at the live bus there and at the latched copy otherwise.
    always_comb begin
        accept     = (state == IDLE) && MEM_ACCESS_EN && EXT_HALT_N;
        resp_entry = (accept && (WAIT_STATES == 0)) ||
                     ((state == BUSY) && (wait_cnt == '0));

        if (state == IDLE) begin
            cur_addr  = MEM_ACCESS_ADDRESS_BUS;
            cur_wdata = MEM_ACCESS_DATA_OUT_BUS;
            cur_rwn   = MEM_ACCESS_READ_WRN;
        end else begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_rwn   = rwn_q;
        end

        hit_ram = cur_addr < 32'(DEPTH);
        hit_led = cur_addr == LED_ADDR;
        hit_sw  = cur_addr == SW_ADDR;
        ram_idx = cur_addr[AW-1:0];

        rd_val = '0;
        if (hit_ram) begin
            rd_val = ram[ram_idx];
        end else if (hit_led) begin
            rd_val = {28'b0, led_q};
        end else if (hit_sw) begin
            rd_val = {24'b0, btn_sync, sw_sync};
        end

        // Gated by RST_N so a request presented while reset is held low can
        // never reach the RAM, which itself has no reset.
        ram_we = resp_entry && !cur_rwn && hit_ram && RST_N;
    end

    // The CPU is frozen during the request cycle, every wait cycle, and any
    // cycle the external halt is low.
    always_comb begin
        CPU_HALT_N = EXT_HALT_N && !((state == IDLE) && MEM_ACCESS_EN) && (state != BUSY);
    end

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
            btn_meta <= BTN;
            btn_sync <= btn_meta;
        end
    end

    // Access FSM plus the registers that update when an access enters RESP.
    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rwn_q      <= 1'b1;
            data_in    <= '0;
            led_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q   <= MEM_ACCESS_ADDRESS_BUS;
                        wdata_q  <= MEM_ACCESS_DATA_OUT_BUS;
                        rwn_q    <= MEM_ACCESS_READ_WRN;
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_STATES > 0) ? BUSY : RESP;
                    end
                end
                BUSY: begin
                    if (wait_cnt == '0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (EXT_HALT_N) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (resp_entry) begin
                if (cur_rwn) begin
                    data_in <= rd_val;
                end else if (hit_led) begin
                    led_q <= cur_wdata[3:0];
                end
                if (!hit_ram && !hit_led && !hit_sw) begin
                    addr_err_q <= 1'b1;
                end
            end
        end
    end

    // Word RAM write port; contents survive reset.
    always_ff @(posedge CK_REF) begin
        if (ram_we) begin
            ram[ram_idx] <= cur_wdata;
        end
    end

    assign MEM_ACCESS_DATA_IN_BUS = data_in;
    assign LED                    = led_q;
    assign ADDR_ERR               = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven and randomized checks of dmem_responder,
// one instance with one wait state and one with none.
module tb_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ext_halt_n;
    logic [3:0]  sw;
    logic [3:0]  btn;

    logic        en, rwn;
    logic [31:0] addr, wdata, rdata;
    logic        halt_n;
    logic [3:0]  led;
    logic        err;

    logic        en0, rwn0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        halt0_n;
    logic [3:0]  led0;
    logic        err0;

    dmem_responder #(.DEPTH(16), .WAIT_STATES(1), .LED_ADDR(32'h100), .SW_ADDR(32'h101)) dut (
        .CK_REF(clk), .RST_N(rst_n),
        .MEM_ACCESS_EN(en), .MEM_ACCESS_READ_WRN(rwn),
        .MEM_ACCESS_ADDRESS_BUS(addr), .MEM_ACCESS_DATA_OUT_BUS(wdata),
        .MEM_ACCESS_DATA_IN_BUS(rdata), .EXT_HALT_N(ext_halt_n), .CPU_HALT_N(halt_n),
        .SW(sw), .BTN(btn), .LED(led), .ADDR_ERR(err)
    );

    dmem_responder #(.DEPTH(16), .WAIT_STATES(0), .LED_ADDR(32'h100), .SW_ADDR(32'h101)) dut0 (
        .CK_REF(clk), .RST_N(rst_n),
        .MEM_ACCESS_EN(en0), .MEM_ACCESS_READ_WRN(rwn0),
        .MEM_ACCESS_ADDRESS_BUS(addr0), .MEM_ACCESS_DATA_OUT_BUS(wdata0),
        .MEM_ACCESS_DATA_IN_BUS(rdata0), .EXT_HALT_N(ext_halt_n), .CPU_HALT_N(halt0_n),
        .SW(sw), .BTN(btn), .LED(led0), .ADDR_ERR(err0)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: memory map state as seen by the CPU.
    logic [31:0] mem_m [16];
    logic [3:0]  led_m;
    logic        err_m;
    logic [31:0] data_m;

    typedef struct {
        bit          rd;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic [3:0]  exp_led;
        bit          exp_err;
    } vec_t;

    vec_t tbl  [16];
    vec_t tbl0 [11];

    logic [31:0] d;
    logic [3:0]  l;
    logic        e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < 32'd16) return mem_m[a[3:0]];
        if (a == 32'h100) return {28'b0, led_m};
        if (a == 32'h101) return {24'b0, btn, sw};
        return 32'h0;
    endfunction

    task automatic model_apply(input bit rd, input logic [31:0] a, input logic [31:0] wd);
        if (rd) begin
            data_m = model_read(a);
        end else if (a < 32'd16) begin
            mem_m[a[3:0]] = wd;
        end else if (a == 32'h100) begin
            led_m = wd[3:0];
        end
        if (!(a < 32'd16 || a == 32'h100 || a == 32'h101)) err_m = 1'b1;
    endtask

    // One access on the one-wait-state instance: request, one wait cycle, response.
    task automatic do_access(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] od, output logic [3:0] ol, output logic oe);
        @(negedge clk);
        en = 1'b1; rwn = rd; addr = a; wdata = wd;
        #1 check("req_halt", {31'b0, halt_n}, 32'h0);
        @(negedge clk);
        check("busy_halt", {31'b0, halt_n}, 32'h0);
        check("busy_data", rdata, data_m);
        en = 1'b0;
        @(negedge clk);
        check("resp_halt", {31'b0, halt_n}, 32'h1);
        od = rdata; ol = led; oe = err;
    endtask

    // One access on the zero-wait-state instance: request then response.
    task automatic do_access0(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] od, output logic [3:0] ol, output logic oe);
        @(negedge clk);
        en0 = 1'b1; rwn0 = rd; addr0 = a; wdata0 = wd;
        #1 check("ws0_req_halt", {31'b0, halt0_n}, 32'h0);
        @(negedge clk);
        check("ws0_resp_halt", {31'b0, halt0_n}, 32'h1);
        od = rdata0; ol = led0; oe = err0;
        en0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 32'h3,   32'hDEADBEEF, 32'h0,        4'h0, 1'b0};
        tbl[1]  = '{1'b1, 32'h3,   32'h0,        32'hDEADBEEF, 4'h0, 1'b0};
        tbl[2]  = '{1'b0, 32'h100, 32'h6,        32'hDEADBEEF, 4'h6, 1'b0};
        tbl[3]  = '{1'b1, 32'h100, 32'h0,        32'h6,        4'h6, 1'b0};
        tbl[4]  = '{1'b1, 32'h101, 32'h0,        32'h5A,       4'h6, 1'b0};
        tbl[5]  = '{1'b0, 32'h101, 32'hFFFFFFFF, 32'h5A,       4'h6, 1'b0};
        tbl[6]  = '{1'b1, 32'h101, 32'h0,        32'h5A,       4'h6, 1'b0};
        tbl[7]  = '{1'b0, 32'hF,   32'h12345678, 32'h5A,       4'h6, 1'b0};
        tbl[8]  = '{1'b1, 32'hF,   32'h0,        32'h12345678, 4'h6, 1'b0};
        tbl[9]  = '{1'b1, 32'h40,  32'h0,        32'h0,        4'h6, 1'b1};
        tbl[10] = '{1'b0, 32'h3,   32'hCAFE0001, 32'h0,        4'h6, 1'b1};
        tbl[11] = '{1'b1, 32'h3,   32'h0,        32'hCAFE0001, 4'h6, 1'b1};
        tbl[12] = '{1'b0, 32'h10,  32'hAAAA5555, 32'hCAFE0001, 4'h6, 1'b1};
        tbl[13] = '{1'b0, 32'h100, 32'hFFFFFFF9, 32'hCAFE0001, 4'h9, 1'b1};
        tbl[14] = '{1'b1, 32'h100, 32'h0,        32'h9,        4'h9, 1'b1};
        tbl[15] = '{1'b1, 32'hF,   32'h0,        32'h12345678, 4'h9, 1'b1};

        tbl0[0]  = '{1'b0, 32'h2,   32'h11,   32'h0,    4'h0, 1'b0};
        tbl0[1]  = '{1'b1, 32'h2,   32'h0,    32'h11,   4'h0, 1'b0};
        tbl0[2]  = '{1'b0, 32'hF,   32'hF0F0, 32'h11,   4'h0, 1'b0};
        tbl0[3]  = '{1'b1, 32'hF,   32'h0,    32'hF0F0, 4'h0, 1'b0};
        tbl0[4]  = '{1'b0, 32'h100, 32'h5,    32'hF0F0, 4'h5, 1'b0};
        tbl0[5]  = '{1'b1, 32'h100, 32'h0,    32'h5,    4'h5, 1'b0};
        tbl0[6]  = '{1'b0, 32'h101, 32'h7,    32'h5,    4'h5, 1'b0};
        tbl0[7]  = '{1'b1, 32'hF,   32'h0,    32'hF0F0, 4'h5, 1'b0};
        tbl0[8]  = '{1'b1, 32'h10,  32'h0,    32'h0,    4'h5, 1'b1};
        tbl0[9]  = '{1'b1, 32'h2,   32'h0,    32'h11,   4'h5, 1'b1};
        tbl0[10] = '{1'b0, 32'h2,   32'h99,   32'h11,   4'h5, 1'b1};

        for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
        led_m = 4'h0; err_m = 1'b0; data_m = 32'h0;

        // Reset with board inputs already set.
        rst_n = 1'b0; ext_halt_n = 1'b1; sw = 4'hA; btn = 4'h5;
        en = 1'b0; rwn = 1'b1; addr = '0; wdata = '0;
        en0 = 1'b0; rwn0 = 1'b1; addr0 = '0; wdata0 = '0;
        repeat (3) @(negedge clk);
        check("rst_halt",  {31'b0, halt_n},  32'h1);
        check("rst_data",  rdata,            32'h0);
        check("rst_led",   {28'b0, led},     32'h0);
        check("rst_err",   {31'b0, err},     32'h0);
        check("rst0_data", rdata0,           32'h0);
        check("rst0_err",  {31'b0, err0},    32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed table on the one-wait-state instance.
        for (int i = 0; i < 16; i++) begin
            do_access(tbl[i].rd, tbl[i].a, tbl[i].wd, d, l, e);
            model_apply(tbl[i].rd, tbl[i].a, tbl[i].wd);
            check($sformatf("tbl%0d_data", i), d, tbl[i].exp_d);
            check($sformatf("tbl%0d_led", i), {28'b0, l}, {28'b0, tbl[i].exp_led});
            check($sformatf("tbl%0d_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
        end

        // Request presented while the external halt is low is ignored.
        @(negedge clk);
        ext_halt_n = 1'b0; en = 1'b1; rwn = 1'b0; addr = 32'h3; wdata = 32'h0BAD0BAD;
        #1 check("exth_idle_halt", {31'b0, halt_n}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("exth_idle_hold", {31'b0, halt_n}, 32'h0);
        end
        en = 1'b0; ext_halt_n = 1'b1;
        #1 check("exth_idle_release", {31'b0, halt_n}, 32'h1);
        do_access(1'b1, 32'h3, 32'h0, d, l, e);
        model_apply(1'b1, 32'h3, 32'h0);
        check("exth_ignored_write", d, 32'hCAFE0001);

        // External halt held low through BUSY and RESP.
        @(negedge clk);
        en = 1'b1; rwn = 1'b1; addr = 32'hF;
        #1 check("hold_req_halt", {31'b0, halt_n}, 32'h0);
        @(negedge clk);
        check("hold_busy_halt", {31'b0, halt_n}, 32'h0);
        en = 1'b0; ext_halt_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hold_resp_halt", {31'b0, halt_n}, 32'h0);
            check("hold_resp_data", rdata, 32'h12345678);
        end
        ext_halt_n = 1'b1; en = 1'b1; rwn = 1'b1; addr = 32'h3;
        #1 check("hold_resp_ignores_en", {31'b0, halt_n}, 32'h1);
        @(negedge clk);
        check("hold_back_to_idle", {31'b0, halt_n}, 32'h0);
        @(negedge clk);
        check("hold_next_busy", {31'b0, halt_n}, 32'h0);
        en = 1'b0;
        @(negedge clk);
        check("hold_next_data", rdata, 32'hCAFE0001);
        model_apply(1'b1, 32'hF, 32'h0);
        model_apply(1'b1, 32'h3, 32'h0);

        // Reset during the wait cycle of a write: the write must not land.
        do_access(1'b0, 32'h2, 32'h22222222, d, l, e);
        model_apply(1'b0, 32'h2, 32'h22222222);
        @(negedge clk);
        en = 1'b1; rwn = 1'b0; addr = 32'h2; wdata = 32'hFFFF0000;
        #1 check("abort_req_halt", {31'b0, halt_n}, 32'h0);
        @(negedge clk);
        check("abort_busy_halt", {31'b0, halt_n}, 32'h0);
        en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("abort_halt", {31'b0, halt_n}, 32'h1);
        check("abort_data", rdata,           32'h0);
        check("abort_led",  {28'b0, led},    32'h0);
        check("abort_err",  {31'b0, err},    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        led_m = 4'h0; err_m = 1'b0; data_m = 32'h0;
        do_access(1'b1, 32'h2, 32'h0, d, l, e);
        model_apply(1'b1, 32'h2, 32'h0);
        check("abort_ram_kept", d, 32'h22222222);

        // Randomized traffic against the model, RAM fully initialised first.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] wd;
            wd = $urandom;
            do_access(1'b0, 32'(i), wd, d, l, e);
            model_apply(1'b0, 32'(i), wd);
            check("init_data", d, data_m);
        end
        for (int i = 0; i < 80; i++) begin
            int unsigned sel;
            bit          rd;
            logic [31:0] a;
            logic [31:0] wd;
            if (i % 20 == 0) begin
                sw = 4'($urandom); btn = 4'($urandom);
                repeat (3) @(negedge clk);
            end
            sel = $urandom_range(0, 9);
            rd  = 1'($urandom);
            wd  = $urandom;
            if (sel < 7)       a = 32'($urandom_range(0, 15));
            else if (sel == 7) a = 32'h100;
            else if (sel == 8) a = 32'h101;
            else               a = 32'h200 + 32'($urandom_range(0, 1000));
            do_access(rd, a, wd, d, l, e);
            model_apply(rd, a, wd);
            check($sformatf("rnd%0d_data a=%h", i, a), d, data_m);
            check($sformatf("rnd%0d_led", i), {28'b0, l}, {28'b0, led_m});
            check($sformatf("rnd%0d_err", i), {31'b0, e}, {31'b0, err_m});
        end

        // Zero-wait-state instance: one-cycle stall, boundary at DEPTH.
        for (int i = 0; i < 11; i++) begin
            do_access0(tbl0[i].rd, tbl0[i].a, tbl0[i].wd, d, l, e);
            check($sformatf("ws0_tbl%0d_data", i), d, tbl0[i].exp_d);
            check($sformatf("ws0_tbl%0d_led", i), {28'b0, l}, {28'b0, tbl0[i].exp_led});
            check($sformatf("ws0_tbl%0d_err", i), {31'b0, e}, {31'b0, tbl0[i].exp_err});
        end
        do_access0(1'b1, 32'h101, 32'h0, d, l, e);
        check("ws0_sw_read", d, {24'b0, btn, sw});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
